apb_rr_arb: RTL and testbench
=============================

// Module: apb_rr_arb
// PURPOSE
//  Single-clock APB N:1 arbiter with a registered cut. NumSlvPorts upstream APB masters share one
//  downstream APB slave. Round-robin grant; one transfer in flight; all downstream signals from flops.
//  Sits behind apb_cdc_intf endpoints where several clock-crossed masters merge into one peripheral bus.
// PARAMETERS
//  NumSlvPorts  2   number of upstream ports (>=1)
//  AddrWidth    32  paddr width
//  DataWidth    32  pwdata/prdata width; StrbWidth = ceil(DataWidth/8)
//  PerfCntWidth 16  width of per-port completed-transfer counters (APB_ARB_PERF_EN only)
// PORTS
//  pclk_i        in  1                        clock
//  preset_i      in  1                        async active-high reset
//  slv_psel_i    in  [NumSlvPorts]            upstream psel
//  slv_penable_i in  [NumSlvPorts]            upstream penable
//  slv_paddr_i   in  [NumSlvPorts][AddrWidth] upstream paddr
//  slv_pwrite_i  in  [NumSlvPorts]            upstream pwrite
//  slv_pprot_i   in  [NumSlvPorts][3]         upstream pprot
//  slv_pwdata_i  in  [NumSlvPorts][DataWidth] upstream pwdata
//  slv_pstrb_i   in  [NumSlvPorts][StrbWidth] upstream pstrb
//  slv_pready_o  out [NumSlvPorts]            one-hot completion pulse
//  slv_prdata_o  out [DataWidth]              shared registered read data
//  slv_pslverr_o out 1                        shared registered error
//  mst_psel_o, mst_penable_o, mst_pwrite_o  out 1; mst_paddr_o out AddrWidth; mst_pprot_o out 3
//  mst_pwdata_o  out DataWidth;  mst_pstrb_o out StrbWidth
//  mst_pready_i  in 1;  mst_prdata_i in DataWidth;  mst_pslverr_i in 1
//  perf_cnt_o    out [NumSlvPorts][PerfCntWidth]  (APB_ARB_PERF_EN only)
// BEHAVIOUR
//  Reset (async, preset_i=1): all outputs 0; state IDLE; last_q = NumSlvPorts-1; counters 0.
//  FSM (apb_arb_pkg::state_e):
//   IDLE  : req = slv_psel_i. If req!=0: pick first set bit searching from (last_q+1) mod N upward
//           with wrap. Latch grant_q, paddr/pwrite/pprot/pwdata/pstrb. -> SETUP.
//   SETUP : mst_psel_o=1, mst_penable_o=0 -> ACCESS.
//   ACCESS: mst_psel_o=1, mst_penable_o=1. Hold until mst_pready_i=1, then capture prdata/pslverr
//           into regs, drop psel/penable -> RESP.
//   RESP  : slv_pready_o[grant_q]=1 for exactly one cycle; slv_prdata_o/slv_pslverr_o valid this
//           cycle, 0 otherwise. last_q <= grant_q -> IDLE.
//  Latency: upstream psel at cycle 0, zero-wait slave -> slv_pready_o at cycle 3. Back-to-back
//   grants separated by one IDLE cycle (IDLE to IDLE turnaround = 4 cycles + slave wait states).
//  Write transfers: prdata captured as-is; not interpreted.
//  Ports not granted see slv_pready_o=0 and wait. No starvation: a requester is granted within
//   NumSlvPorts transfers.
//  Upstream psel dropped before RESP: protocol violation. Downstream transfer still completes;
//   RESP pulse still issued; sim-only assertion fires.
//  Simultaneous reqs on all ports after reset: port 0, then 1, ..., N-1, then 0.
//  NumSlvPorts=1: grant index width max(1,$clog2(N)); always port 0.
//  preset_i mid-ACCESS: downstream psel/penable drop immediately (async); any pending response is
//   lost.
// CONFIGURATION
//  APB_ARB_PERF_EN defined: perf_cnt_o present. perf_cnt_o[grant_q] increments in RESP and
//   saturates at all-ones.
//  Not defined: port and counters absent; behaviour otherwise identical.
// STRUCTURE
//  apb_arb_pkg: state_e {IDLE,SETUP,ACCESS,RESP}, PPROT_W=3.
//  Sub-module apb_arb_rr_pick: combinational; req vector + last index -> grant index + valid.
// TESTING
//  Single port 1, write 0xA5A5_0001 to 0x100, zero-wait slave -> mst signals match; slv_pready_o=2'b10
//   at cycle 3.
//  Ports 0,1 request together from reset -> grants 0 then 1. Both re-request -> 0 again.
//   No grant repeats while the other port waits.
//  Read, slave 5 wait states, prdata=0xDEAD_BEEF, pslverr=1 -> upstream sees both on pready cycle;
//   prdata=0 afterwards.
//  Assert preset_i in ACCESS -> all outputs 0 same cycle. After release, port 0 granted first.
//  Random 1000 txns, 4 ports, random waits -> scoreboard matches requests and responses; every
//   pready is one-hot, single-cycle.
//  APB_ARB_PERF_EN, PerfCntWidth=2, 5 txns on port 0 -> perf_cnt_o[0]=3 (saturated),
//   others 0.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types for the APB round-robin arbiter.
package apb_arb_pkg;

  localparam int unsigned PPROT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Index width that stays legal for a single port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_arb_rr_pick.sv
// Combinational round-robin picker: first requester searching upward from last_idx+1 with wrap.
module apb_arb_rr_pick #(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned IdxW     = 1
) (
  input  logic [NumPorts-1:0] req,
  input  logic [IdxW-1:0]     last_idx,
  output logic [IdxW-1:0]     grant,
  output logic                valid
);

  always_comb begin
    int unsigned l;
    int unsigned d;
    int unsigned best;
    grant = '0;
    l     = 32'(last_idx);
    d     = 0;
    best  = NumPorts;
    // Lowest rotated distance from the last winner has highest priority.
    for (int unsigned j = 0; j < NumPorts; j++) begin
      d = (j + NumPorts - l - 1) % NumPorts;
      if (req[j] && (d < best)) begin
        best  = d;
        grant = IdxW'(j);
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/apb_rr_arb.sv
// APB N:1 round-robin arbiter with registered downstream outputs.
// Define APB_ARB_PERF_EN to add saturating per-port completed-transfer counters (perf_cnt_o).
module apb_rr_arb
  import apb_arb_pkg::*;
#(
  parameter int unsigned NumSlvPorts  = 2,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned PerfCntWidth = 16,
  localparam int unsigned StrbWidth   = (DataWidth + 7) / 8
) (
  input  logic                                   pclk_i,
  input  logic                                   preset_i,
  input  logic [NumSlvPorts-1:0]                 slv_psel_i,
  input  logic [NumSlvPorts-1:0]                 slv_penable_i,
  input  logic [NumSlvPorts-1:0][AddrWidth-1:0]  slv_paddr_i,
  input  logic [NumSlvPorts-1:0]                 slv_pwrite_i,
  input  logic [NumSlvPorts-1:0][PPROT_W-1:0]    slv_pprot_i,
  input  logic [NumSlvPorts-1:0][DataWidth-1:0]  slv_pwdata_i,
  input  logic [NumSlvPorts-1:0][StrbWidth-1:0]  slv_pstrb_i,
  output logic [NumSlvPorts-1:0]                 slv_pready_o,
  output logic [DataWidth-1:0]                   slv_prdata_o,
  output logic                                   slv_pslverr_o,
  output logic                                   mst_psel_o,
  output logic                                   mst_penable_o,
  output logic                                   mst_pwrite_o,
  output logic [AddrWidth-1:0]                   mst_paddr_o,
  output logic [PPROT_W-1:0]                     mst_pprot_o,
  output logic [DataWidth-1:0]                   mst_pwdata_o,
  output logic [StrbWidth-1:0]                   mst_pstrb_o,
  input  logic                                   mst_pready_i,
  input  logic [DataWidth-1:0]                   mst_prdata_i,
  input  logic                                   mst_pslverr_i
`ifdef APB_ARB_PERF_EN
  ,
  output logic [NumSlvPorts-1:0][PerfCntWidth-1:0] perf_cnt_o
`endif
);

  localparam int unsigned IdxW = idx_width(NumSlvPorts);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        grant_q, last_q, pick_idx;
  logic                   pick_valid;
  logic [NumSlvPorts-1:0] grant_oh;

  logic                   psel_q, penable_q, pwrite_q;
  logic [AddrWidth-1:0]   paddr_q;
  logic [PPROT_W-1:0]     pprot_q;
  logic [DataWidth-1:0]   pwdata_q;
  logic [StrbWidth-1:0]   pstrb_q;
  logic [NumSlvPorts-1:0] pready_q;
  logic [DataWidth-1:0]   prdata_q;
  logic                   pslverr_q;

  // Upstream penable carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = ^slv_penable_i;

  apb_arb_rr_pick #(
    .NumPorts (NumSlvPorts),
    .IdxW     (IdxW)
  ) u_pick (
    .req      (slv_psel_i),
    .last_idx (last_q),
    .grant    (pick_idx),
    .valid    (pick_valid)
  );

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (mst_pready_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IdxW'(NumSlvPorts - 1);
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pprot_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pready_q  <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q  <= pick_idx;
            paddr_q  <= slv_paddr_i[pick_idx];
            pwrite_q <= slv_pwrite_i[pick_idx];
            pprot_q  <= slv_pprot_i[pick_idx];
            pwdata_q <= slv_pwdata_i[pick_idx];
            pstrb_q  <= slv_pstrb_i[pick_idx];
            psel_q   <= 1'b1;
          end
        end
        SETUP: penable_q <= 1'b1;
        ACCESS: begin
          if (mst_pready_i) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            prdata_q  <= mst_prdata_i;
            pslverr_q <= mst_pslverr_i;
            pready_q  <= grant_oh;
          end
        end
        RESP: begin
          pready_q  <= '0;
          prdata_q  <= '0;
          pslverr_q <= 1'b0;
          last_q    <= grant_q;
        end
        default: ;
      endcase
    end
  end

  assign mst_psel_o    = psel_q;
  assign mst_penable_o = penable_q;
  assign mst_pwrite_o  = pwrite_q;
  assign mst_paddr_o   = paddr_q;
  assign mst_pprot_o   = pprot_q;
  assign mst_pwdata_o  = pwdata_q;
  assign mst_pstrb_o   = pstrb_q;
  assign slv_pready_o  = pready_q;
  assign slv_prdata_o  = prdata_q;
  assign slv_pslverr_o = pslverr_q;

`ifdef APB_ARB_PERF_EN
  logic [NumSlvPorts-1:0][PerfCntWidth-1:0] perf_q;

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      perf_q <= '0;
    end else if ((state_q == RESP) && (perf_q[grant_q] != '1)) begin
      perf_q[grant_q] <= perf_q[grant_q] + PerfCntWidth'(1);
    end
  end

  assign perf_cnt_o = perf_q;
`endif

`ifndef SYNTHESIS
  // A granted master must keep psel up until its response pulse.
  always_ff @(posedge pclk_i) begin
    if (!preset_i && ((state_q == SETUP) || (state_q == ACCESS))) begin
      assert (slv_psel_i[grant_q])
      else $error("apb_rr_arb: port %0d dropped psel mid-transfer", grant_q);
    end
  end
`endif

endmodule

// File: tb/tb_apb_rr_arb.sv
// Directed and randomized checks of apb_rr_arb (4 ports) against a transaction-level model.
module tb_apb_rr_arb;

  localparam int unsigned N = 4;

  logic                 pclk = 1'b0;
  logic                 preset = 1'b1;
  logic [N-1:0]         s_psel, s_pen, s_pwrite;
  logic [N-1:0][31:0]   s_paddr, s_pwdata;
  logic [N-1:0][2:0]    s_pprot;
  logic [N-1:0][3:0]    s_pstrb;
  logic [N-1:0]         slv_pready_o;
  logic [31:0]          slv_prdata_o;
  logic                 slv_pslverr_o;
  logic                 mst_psel_o, mst_penable_o, mst_pwrite_o;
  logic [31:0]          mst_paddr_o, mst_pwdata_o;
  logic [2:0]           mst_pprot_o;
  logic [3:0]           mst_pstrb_o;
  logic                 s_mpready, s_mpslverr;
  logic [31:0]          s_mprdata;
`ifdef APB_ARB_PERF_EN
  logic [N-1:0][1:0]    perf_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  apb_rr_arb #(
    .NumSlvPorts  (N),
    .AddrWidth    (32),
    .DataWidth    (32),
    .PerfCntWidth (2)
  ) dut (
    .pclk_i        (pclk),
    .preset_i      (preset),
    .slv_psel_i    (s_psel),
    .slv_penable_i (s_pen),
    .slv_paddr_i   (s_paddr),
    .slv_pwrite_i  (s_pwrite),
    .slv_pprot_i   (s_pprot),
    .slv_pwdata_i  (s_pwdata),
    .slv_pstrb_i   (s_pstrb),
    .slv_pready_o  (slv_pready_o),
    .slv_prdata_o  (slv_prdata_o),
    .slv_pslverr_o (slv_pslverr_o),
    .mst_psel_o    (mst_psel_o),
    .mst_penable_o (mst_penable_o),
    .mst_pwrite_o  (mst_pwrite_o),
    .mst_paddr_o   (mst_paddr_o),
    .mst_pprot_o   (mst_pprot_o),
    .mst_pwdata_o  (mst_pwdata_o),
    .mst_pstrb_o   (mst_pstrb_o),
    .mst_pready_i  (s_mpready),
    .mst_prdata_i  (s_mprdata),
    .mst_pslverr_i (s_mpslverr)
`ifdef APB_ARB_PERF_EN
    ,
    .perf_cnt_o    (perf_cnt_o)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    preset     = 1'b1;
    s_psel     = '0;
    s_pen      = '0;
    s_mpready  = 1'b0;
    s_mprdata  = '0;
    s_mpslverr = 1'b0;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
  endtask

  task automatic wait_ready(output logic [N-1:0] seen);
    seen = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge pclk);
      if (slv_pready_o != '0) begin
        seen = slv_pready_o;
        break;
      end
    end
  endtask

  task automatic simple_txn(input int p);
    logic [N-1:0] seen, exp;
    exp       = '0;
    exp[p]    = 1'b1;
    s_psel[p] = 1'b1;
    s_mpready = 1'b1;
    wait_ready(seen);
    check("simple_txn_ready", seen, exp);
    s_psel[p] = 1'b0;
  endtask

  // Random-phase model state
  int           last, issued, done_n, exp_port, granted, slv_cnt, slv_target, resp_port, acc_cnt;
  bit           resp_due, got;
  bit           pend[N];
  int           others[N];
  logic [31:0]  t_addr[N], t_wdata[N];
  logic         t_write[N];
  logic [3:0]   t_strb[N];
  logic [2:0]   t_prot[N];
  logic [31:0]  resp_rdata;
  logic         resp_err, pen_before;
  logic [N-1:0] req_snap, seen, exp_oh;

  initial begin
    s_paddr  = '0;
    s_pwdata = '0;
    s_pwrite = '0;
    s_pprot  = '0;
    s_pstrb  = '0;
    do_reset();

    // Reset state
    check("rst_psel", mst_psel_o, 1'b0);
    check("rst_penable", mst_penable_o, 1'b0);
    check("rst_paddr", mst_paddr_o, 32'h0);
    check("rst_pready", slv_pready_o, 4'h0);
    check("rst_prdata", {slv_prdata_o, slv_pslverr_o}, 33'h0);

    // Single write on port 1, zero-wait slave
    s_psel[1]   = 1'b1;
    s_pwrite[1] = 1'b1;
    s_paddr[1]  = 32'h100;
    s_pwdata[1] = 32'hA5A5_0001;
    s_pstrb[1]  = 4'hF;
    s_pprot[1]  = 3'h2;
    s_mpready   = 1'b1;
    @(negedge pclk);
    check("wr_setup", {mst_psel_o, mst_penable_o}, 2'b10);
    check("wr_fields", {mst_paddr_o, mst_pwdata_o, mst_pwrite_o, mst_pstrb_o, mst_pprot_o},
          {32'h100, 32'hA5A5_0001, 1'b1, 4'hF, 3'h2});
    check("wr_c1_pready", slv_pready_o, 4'h0);
    @(negedge pclk);
    check("wr_access", {mst_psel_o, mst_penable_o}, 2'b11);
    @(negedge pclk);
    check("wr_c3_pready", slv_pready_o, 4'b0010);
    check("wr_c3_psel_low", {mst_psel_o, mst_penable_o}, 2'b00);
    s_psel[1] = 1'b0;
    @(negedge pclk);
    check("wr_pready_pulse", slv_pready_o, 4'h0);

    // Simultaneous requests from reset: 0, 1, then 0 again
    do_reset();
    s_mpready = 1'b1;
    s_psel    = 4'b0011;
    for (int r = 0; r < 2; r++) begin
      wait_ready(seen);
      check("rr_first", seen, 4'b0001);
      s_psel[0] = 1'b0;
      wait_ready(seen);
      check("rr_second", seen, 4'b0010);
      s_psel[1] = 1'b0;
      if (r == 0) s_psel = 4'b0011;
    end

    // Read with five wait states and a slave error
    s_mpready   = 1'b0;
    s_psel[2]   = 1'b1;
    s_pwrite[2] = 1'b0;
    s_paddr[2]  = 32'h200;
    acc_cnt     = 0;
    got         = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge pclk);
      if (slv_pready_o != '0) begin
        got = 1'b1;
        check("rd_pready", slv_pready_o, 4'b0100);
        check("rd_data_err", {slv_prdata_o, slv_pslverr_o}, {32'hDEAD_BEEF, 1'b1});
      end
      s_mpready = 1'b0;
      if (mst_psel_o && mst_penable_o) begin
        acc_cnt++;
        if (acc_cnt == 6) begin
          s_mpready  = 1'b1;
          s_mprdata  = 32'hDEAD_BEEF;
          s_mpslverr = 1'b1;
        end
      end
    end
    check("rd_seen", got, 1'b1);
    check("rd_access_cycles", acc_cnt, 6);
    s_psel[2]  = 1'b0;
    s_mprdata  = '0;
    s_mpslverr = 1'b0;
    @(negedge pclk);
    check("rd_after", {slv_pready_o, slv_prdata_o, slv_pslverr_o}, 37'h0);

    // Reset asserted mid-ACCESS
    s_mpready = 1'b0;
    s_psel[3] = 1'b1;
    s_paddr[3] = 32'h300;
    for (int i = 0; i < 10 && !mst_penable_o; i++) @(negedge pclk);
    pen_before = mst_penable_o;
    check("rst_mid_reached_access", pen_before, 1'b1);
    preset = 1'b1;
    #1;
    check("rst_mid_outputs",
          {mst_psel_o, mst_penable_o, mst_pwrite_o, mst_paddr_o, mst_pwdata_o, mst_pstrb_o,
           mst_pprot_o, slv_pready_o, slv_prdata_o, slv_pslverr_o}, 111'h0);
    s_psel = '0;
    @(negedge pclk);
    preset    = 1'b0;
    s_psel    = 4'hF;
    s_mpready = 1'b1;
    wait_ready(seen);
    check("rst_mid_first_grant", seen, 4'b0001);
    s_psel = '0;
    repeat (3) @(negedge pclk);

    // Random traffic against a transaction-level round-robin model
    do_reset();
    last     = N - 1;
    issued   = 0;
    done_n   = 0;
    resp_due = 1'b0;
    granted  = 0;
    slv_cnt  = 0;
    slv_target = 0;
    for (int p = 0; p < N; p++) begin
      pend[p]   = 1'b0;
      others[p] = 0;
    end
    for (int cyc = 0; cyc < 40000 && done_n < 1000; cyc++) begin
      @(negedge pclk);
      req_snap = s_psel;
      if (resp_due) begin
        exp_oh            = '0;
        exp_oh[resp_port] = 1'b1;
        check("rnd_resp", {slv_pready_o, slv_prdata_o, slv_pslverr_o},
              {exp_oh, resp_rdata, resp_err});
        s_psel[resp_port] = 1'b0;
        s_pen[resp_port]  = 1'b0;
        pend[resp_port]   = 1'b0;
        done_n++;
        resp_due = 1'b0;
      end else begin
        check("rnd_quiet", {slv_pready_o, slv_prdata_o, slv_pslverr_o}, 37'h0);
      end
      if (mst_psel_o && !mst_penable_o) begin
        exp_port = -1;
        for (int k = 1; k <= N; k++) begin
          if (exp_port < 0 && req_snap[(last + k) % N]) exp_port = (last + k) % N;
        end
        check("rnd_grant_has_req", |req_snap, 1'b1);
        if (exp_port >= 0) begin
          check("rnd_grant_fields",
                {mst_paddr_o, mst_pwdata_o, mst_pwrite_o, mst_pstrb_o, mst_pprot_o},
                {t_addr[exp_port], t_wdata[exp_port], t_write[exp_port], t_strb[exp_port],
                 t_prot[exp_port]});
          check("rnd_no_starve", others[exp_port] <= N - 1, 1'b1);
          for (int q = 0; q < N; q++) if (q != exp_port && req_snap[q]) others[q]++;
          others[exp_port] = 0;
          last       = exp_port;
          granted    = exp_port;
          slv_cnt    = 0;
          slv_target = $urandom_range(0, 3);
        end
      end
      s_mpready = 1'b0;
      if (mst_psel_o && mst_penable_o) begin
        slv_cnt++;
        if (slv_cnt > slv_target) begin
          s_mpready  = 1'b1;
          s_mprdata  = $urandom;
          s_mpslverr = 1'($urandom_range(0, 1));
          resp_due   = 1'b1;
          resp_port  = granted;
          resp_rdata = s_mprdata;
          resp_err   = s_mpslverr;
        end
      end
      for (int p = 0; p < N; p++) begin
        if (!pend[p]) begin
          if (issued < 1000 && $urandom_range(0, 2) == 0) begin
            pend[p]     = 1'b1;
            issued++;
            t_addr[p]   = {2'(p), 30'($urandom)};
            t_wdata[p]  = $urandom;
            t_write[p]  = 1'($urandom_range(0, 1));
            t_strb[p]   = 4'($urandom);
            t_prot[p]   = 3'($urandom);
            s_psel[p]   = 1'b1;
            s_pen[p]    = 1'b0;
            s_paddr[p]  = t_addr[p];
            s_pwdata[p] = t_wdata[p];
            s_pwrite[p] = t_write[p];
            s_pstrb[p]  = t_strb[p];
            s_pprot[p]  = t_prot[p];
          end
        end else begin
          s_pen[p] = 1'b1;
        end
      end
    end
    check("rnd_completed", done_n, 1000);
    s_psel    = '0;
    s_pen     = '0;
    s_mpready = 1'b0;
    repeat (3) @(negedge pclk);

`ifdef APB_ARB_PERF_EN
    // Counter saturation on port 0
    do_reset();
    for (int i = 0; i < 5; i++) simple_txn(0);
    @(negedge pclk);
    check("perf_port0_sat", perf_cnt_o[0], 2'd3);
    check("perf_others", {perf_cnt_o[3], perf_cnt_o[2], perf_cnt_o[1]}, 6'h0);
`else
    simple_txn(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
